// File: rtl/block_swap_engine.sv
// -----------------------------------------------------------------------------
// block_swap_engine
//
// Purpose:
//   OBI manager that either exchanges two equal-sized word blocks A and B in
//   memory (swap mode) or copies block B over block A (load-only mode).
//   It keeps exactly one OBI transaction outstanding at a time.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   block_swap_on_i        engine enable; dropping it mid-run aborts cleanly
//   block_only_load_on_i   1 = copy B->A, 0 = swap A<->B (latched at start)
//   start_i                single-cycle start request (IDLE + enabled only)
//   addr_a_i, addr_b_i     word-aligned byte base addresses of A and B
//   num_words_i            number of 32-bit words to process
//   obi_req_o / obi_rsp_i  OBI manager request / response
//   busy_o                 operation in progress
//   done_o                 one-cycle end-of-operation pulse
//   aborted_o              sticky: last run stopped because enable dropped
//   err_o                  sticky: last run saw an OBI error
//
// Optional feature macro: BLOCK_SWAP_ERR_ABORT_EN
//   Defined   : r.err on a response sets err_o and ends the run early.
//   Undefined : r.err is ignored and err_o is tied to 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package obi_pkg;
   typedef struct packed {
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32'd32, DataWidth: 32'd32, IdWidth: 32'd1};

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [0:0]  aid;
   } obi_a_chan_t;

   typedef struct packed {
      obi_a_chan_t a;
      logic        req;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } obi_r_chan_t;

   typedef struct packed {
      obi_r_chan_t r;
      logic        gnt;
      logic        rvalid;
   } obi_rsp_t;
endpackage

module block_swap_engine #(
   parameter obi_pkg::obi_cfg_t ObiCfg    = obi_pkg::ObiDefaultConfig,
   parameter type               obi_req_t = obi_pkg::obi_req_t,
   parameter type               obi_rsp_t = obi_pkg::obi_rsp_t,
   parameter int unsigned       CntWidth  = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                block_swap_on_i,
   input  logic                block_only_load_on_i,
   input  logic                start_i,
   input  logic [31:0]         addr_a_i,
   input  logic [31:0]         addr_b_i,
   input  logic [CntWidth-1:0] num_words_i,
   output obi_req_t            obi_req_o,
   input  obi_rsp_t            obi_rsp_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                aborted_o,
   output logic                err_o
);

   localparam int unsigned WordShift = $clog2(ObiCfg.DataWidth / 8);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_e;

   state_e              state_q, state_d;
   logic                wait_q, wait_d;       // 0: request phase, 1: wait phase
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;     // also holds B's word on the way to A
   logic [31:0]         base_a_q, base_a_d;
   logic [31:0]         base_b_q, base_b_d;
   logic [31:0]         tmp_a_q, tmp_a_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [CntWidth-1:0] num_q, num_d;
   logic                load_q, load_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                err_q, err_d;

   logic [CntWidth-1:0] cnt_inc_s;
   logic [31:0]         off_cur_s, off_next_s;
   logic                rsp_err_s;
   logic                last_s;
   logic                unused_s;

   function automatic logic [31:0] word_offset(input logic [CntWidth-1:0] idx);
      return 32'(idx) << WordShift;
   endfunction

   assign cnt_inc_s  = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
   assign off_cur_s  = word_offset(cnt_q);
   assign off_next_s = word_offset(cnt_inc_s);
   // The last transaction of a word is WR_B in swap mode, WR_A in load-only mode.
   assign last_s     = (state_q == WR_B) || ((state_q == WR_A) && load_q);

   // Next-state and next-output computation for the transfer sequencer.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      base_a_d  = base_a_q;
      base_b_d  = base_b_q;
      tmp_a_d   = tmp_a_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      load_d    = load_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      aborted_d = aborted_q;
      err_d     = err_q;
      rsp_err_s = 1'b0;
`ifdef BLOCK_SWAP_ERR_ABORT_EN
      rsp_err_s = obi_rsp_i.r.err;
`endif
      case (state_q)
         IDLE: begin
            if (start_i && block_swap_on_i) begin
               base_a_d  = addr_a_i;
               base_b_d  = addr_b_i;
               num_d     = num_words_i;
               load_d    = block_only_load_on_i;
               cnt_d     = '0;
               aborted_d = 1'b0;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               wait_d    = 1'b0;
               we_d      = 1'b0;
               if (num_words_i == '0) begin
                  state_d = DONE;
                  req_d   = 1'b0;
               end else if (block_only_load_on_i) begin
                  state_d = RD_B;
                  req_d   = 1'b1;
                  addr_d  = addr_b_i;
               end else begin
                  state_d = RD_A;
                  req_d   = 1'b1;
                  addr_d  = addr_a_i;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD_A, RD_B, WR_A, WR_B: begin
            if (!wait_q) begin
               // Hold the request stable until granted.
               if (obi_rsp_i.gnt) begin
                  req_d  = 1'b0;
                  wait_d = 1'b1;
               end else begin
                  req_d  = 1'b1;
               end
            end else if (obi_rsp_i.rvalid) begin
               wait_d = 1'b0;
               if (state_q == RD_A) begin
                  tmp_a_d = obi_rsp_i.r.rdata;
               end else begin
                  tmp_a_d = tmp_a_q;
               end
               if (last_s) begin
                  cnt_d = cnt_inc_s;
               end else begin
                  cnt_d = cnt_q;
               end
               if (rsp_err_s) begin
                  // Failed transaction: stop before any further request.
                  err_d   = 1'b1;
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (last_s && (cnt_inc_s == num_q)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else if (!block_swap_on_i) begin
                  // Enable dropped: the handshake just finished, launch nothing new.
                  aborted_d = 1'b1;
                  state_d   = DONE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  req_d = 1'b1;
                  if (last_s) begin
                     we_d = 1'b0;
                     if (load_q) begin
                        state_d = RD_B;
                        addr_d  = base_b_q + off_next_s;
                     end else begin
                        state_d = RD_A;
                        addr_d  = base_a_q + off_next_s;
                     end
                  end else begin
                     case (state_q)
                        RD_A: begin
                           state_d = RD_B;
                           we_d    = 1'b0;
                           addr_d  = base_b_q + off_cur_s;
                        end
                        RD_B: begin
                           state_d = WR_A;
                           we_d    = 1'b1;
                           addr_d  = base_a_q + off_cur_s;
                           wdata_d = obi_rsp_i.r.rdata;
                        end
                        default: begin
                           state_d = WR_B;
                           we_d    = 1'b1;
                           addr_d  = base_b_q + off_cur_s;
                           wdata_d = tmp_a_q;
                        end
                     endcase
                  end
               end
            end else begin
               req_d = 1'b0;
            end
         end
         DONE: begin
            // Zero-word runs arrive here with done_q low and pulse one cycle later.
            if (!done_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         wait_q    <= 1'b0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= 32'h0000_0000;
         wdata_q   <= 32'h0000_0000;
         base_a_q  <= 32'h0000_0000;
         base_b_q  <= 32'h0000_0000;
         tmp_a_q   <= 32'h0000_0000;
         cnt_q     <= '0;
         num_q     <= '0;
         load_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         base_a_q  <= base_a_d;
         base_b_q  <= base_b_d;
         tmp_a_q   <= tmp_a_d;
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         load_q    <= load_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         err_q     <= err_d;
      end
   end

   // OBI request assembly from registered fields.
   always_comb begin
      obi_req_o         = '0;
      obi_req_o.req     = req_q;
      obi_req_o.a.addr  = addr_q;
      obi_req_o.a.we    = we_q;
      obi_req_o.a.be    = 4'hF;
      obi_req_o.a.wdata = wdata_q;
      obi_req_o.a.aid   = 1'b0;
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign aborted_o = aborted_q;
`ifdef BLOCK_SWAP_ERR_ABORT_EN
   assign err_o     = err_q;
`else
   assign err_o     = 1'b0;
`endif

   assign unused_s = ^{obi_rsp_i.r.rid, obi_rsp_i.r.err, err_q};

endmodule

// File: tb/tb_block_swap_engine.sv
// -----------------------------------------------------------------------------
// tb_block_swap_engine
//
// Table of operations applied to block_swap_engine with an in-bench OBI memory.
// Expected OBI transactions are queued when an operation is launched and popped
// as the DUT hands them over; final memory, latency and status are compared
// against hand-derived constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_block_swap_engine;

   typedef struct {
      logic        load;
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] n;
      int          hold;        // gnt withheld on the first request
      int          preset;      // 1: swap values, 2: load values, 0: pattern
      int          drop_word;   // drop enable during WR_A of this word (-1 none)
      logic        err_inj;     // r.err on the word-0 read of B
      logic        poke;        // start/mode/address poke while busy
      int          exp_txns;
      int          exp_cycles;
      logic        exp_aborted;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n;
   logic en, load, start;
   logic [31:0] addr_a, addr_b;
   logic [15:0] num;
   obi_pkg::obi_req_t req_s;
   obi_pkg::obi_rsp_t rsp_s;
   logic busy, done, aborted, err;

   int vectors = 0;
   int miscompares = 0;
   int txn_cnt = 0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] exp_mem [logic [31:0]];
   txn_t exp_q [$];
   vec_t vecs [7];

   logic        pend;
   logic [31:0] pend_data;
   logic        pend_err;
   int          hold_left;
   logic        hold_active;
   logic [31:0] saved_addr;
   logic        saved_we;
   logic        err_arm;
   logic [31:0] err_addr;

   block_swap_engine dut (
      .clk_i                (clk),
      .rst_ni               (rst_n),
      .block_swap_on_i      (en),
      .block_only_load_on_i (load),
      .start_i              (start),
      .addr_a_i             (addr_a),
      .addr_b_i             (addr_b),
      .num_words_i          (num),
      .obi_req_o            (req_s),
      .obi_rsp_i            (rsp_s),
      .busy_o               (busy),
      .done_o               (done),
      .aborted_o            (aborted),
      .err_o                (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Hand a granted transaction to the memory and the scoreboard.
   task automatic serve();
      txn_t e;
      txn_cnt++;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_txn: got addr %h we %0d, expected none", req_s.a.addr, req_s.a.we);
      end else begin
         e = exp_q.pop_front();
         chk("txn_addr", req_s.a.addr, e.addr);
         chk("txn_we", 32'(req_s.a.we), 32'(e.we));
         if (e.we) chk("txn_wdata", req_s.a.wdata, e.wdata);
         chk("txn_be", 32'(req_s.a.be), 32'h0000_000F);
      end
      if (req_s.a.we) begin
         mem[req_s.a.addr] = req_s.a.wdata;
         pend_data = 32'h0000_0000;
         pend_err  = 1'b0;
      end else begin
         pend_data = mem_rd(req_s.a.addr);
         pend_err  = err_arm && (req_s.a.addr == err_addr);
      end
      pend = 1'b1;
   endtask

   // One clock: subordinate behaviour evaluated at the falling edge.
   task automatic tick();
      @(negedge clk);
      if (!rst_n) begin
         rsp_s = '0;
         pend = 1'b0;
         hold_active = 1'b0;
         return;
      end
      rsp_s.rvalid  = pend;
      rsp_s.r.rdata = pend_data;
      rsp_s.r.err   = pend_err;
      if (pend) chk("one_outstanding", 32'(req_s.req), 32'h0);
      if (hold_active) begin
         chk("hold_req", 32'(req_s.req), 32'h1);
         chk("hold_addr", req_s.a.addr, saved_addr);
         chk("hold_we", 32'(req_s.a.we), 32'(saved_we));
      end
      hold_active = 1'b0;
      pend = 1'b0;
      rsp_s.gnt = 1'b0;
      if (req_s.req && !rsp_s.rvalid) begin
         if (hold_left > 0) begin
            hold_left--;
            hold_active = 1'b1;
            saved_addr = req_s.a.addr;
            saved_we = req_s.a.we;
         end else begin
            rsp_s.gnt = 1'b1;
            serve();
         end
      end
   endtask

   // Queue the expected transactions and final memory of an operation.
   task automatic build_model(input vec_t v);
      logic [31:0] ai, bi, va, vb;
      bit stop;
      exp_q.delete();
      exp_mem.delete();
      for (int k = 0; k < int'(v.n); k++) begin
         ai = v.a + 32'(k) * 32'd4;
         bi = v.b + 32'(k) * 32'd4;
         exp_mem[ai] = mem_rd(ai);
         exp_mem[bi] = mem_rd(bi);
      end
      stop = 1'b0;
      for (int k = 0; k < int'(v.n) && !stop; k++) begin
         ai = v.a + 32'(k) * 32'd4;
         bi = v.b + 32'(k) * 32'd4;
         va = mem_rd(ai);
         vb = mem_rd(bi);
         if (!v.load) exp_q.push_back('{ai, 1'b0, 32'h0});
         exp_q.push_back('{bi, 1'b0, 32'h0});
`ifdef BLOCK_SWAP_ERR_ABORT_EN
         if (v.err_inj && k == 0) stop = 1'b1;
`endif
         if (!stop) begin
            exp_q.push_back('{ai, 1'b1, vb});
            exp_mem[ai] = vb;
            if (v.drop_word == k) begin
               stop = 1'b1;
            end else if (!v.load) begin
               exp_q.push_back('{bi, 1'b1, va});
               exp_mem[bi] = va;
            end
         end
      end
   endtask

   task automatic run_op(input vec_t v);
      int cyc;
      int t0;
      if (v.preset == 1) begin
         mem[v.a] = 32'h1111_1111;
         mem[v.a + 32'd4] = 32'h2222_2222;
         mem[v.b] = 32'hAAAA_AAAA;
         mem[v.b + 32'd4] = 32'hBBBB_BBBB;
      end else if (v.preset == 2) begin
         for (int k = 0; k < 3; k++) mem[v.b + 32'(k) * 32'd4] = 32'(k + 1);
      end
      build_model(v);
      hold_left = v.hold;
      err_arm = v.err_inj;
      err_addr = v.b;
      addr_a = v.a;
      addr_b = v.b;
      num = v.n;
      load = v.load;
      start = 1'b1;
      t0 = txn_cnt;
      tick();
      start = 1'b0;
      chk("busy_rise", 32'(busy), 32'h1);
      cyc = 0;
      while (!done && cyc < 400) begin
         tick();
         cyc++;
         if (v.poke && cyc == 3) begin
            start = 1'b1;
            load = ~v.load;
            addr_a = 32'hDEAD_0000;
            num = 16'd7;
         end else begin
            start = 1'b0;
         end
         if (v.drop_word >= 0 && req_s.req && req_s.a.we &&
             req_s.a.addr == v.a + 32'(v.drop_word) * 32'd4) en = 1'b0;
      end
      chk("done_latency", cyc, v.exp_cycles);
      chk("busy_at_done", 32'(busy), 32'h0);
      chk("aborted", 32'(aborted), 32'(v.exp_aborted));
      chk("err", 32'(err), 32'(v.exp_err));
      tick();
      chk("done_width", 32'(done), 32'h0);
      tick();
      chk("txn_count", txn_cnt - t0, v.exp_txns);
      chk("queue_empty", exp_q.size(), 0);
      foreach (exp_mem[k]) chk($sformatf("mem@%h", k), mem_rd(k), exp_mem[k]);
      en = 1'b1;
      load = v.load;
      err_arm = 1'b0;
   endtask

   initial begin
      vec_t rv;
      rst_n = 1'b0;
      en = 1'b0;
      load = 1'b0;
      start = 1'b0;
      addr_a = 32'h0;
      addr_b = 32'h0;
      num = 16'd0;
      rsp_s = '0;
      pend = 1'b0;
      pend_data = 32'h0;
      pend_err = 1'b0;
      hold_left = 0;
      hold_active = 1'b0;
      saved_addr = 32'h0;
      saved_we = 1'b0;
      err_arm = 1'b0;
      err_addr = 32'h0;

      vecs[0] = '{1'b0, 32'h0000_0100, 32'h0000_0200, 16'd2, 0, 1, -1, 1'b0, 1'b0, 8, 16, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0300, 32'h0000_0400, 16'd3, 0, 2, -1, 1'b0, 1'b0, 6, 12, 1'b0, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0500, 32'h0000_0600, 16'd2, 5, 1, -1, 1'b0, 1'b1, 8, 21, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_0700, 32'h0000_0800, 16'd0, 0, 0, -1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 32'h0000_1000, 32'h0000_2000, 16'd4, 0, 0, 1, 1'b0, 1'b0, 7, 14, 1'b1, 1'b0};
`ifdef BLOCK_SWAP_ERR_ABORT_EN
      vecs[5] = '{1'b0, 32'h0000_3000, 32'h0000_4000, 16'd2, 0, 1, -1, 1'b1, 1'b0, 2, 4, 1'b0, 1'b1};
`else
      vecs[5] = '{1'b0, 32'h0000_3000, 32'h0000_4000, 16'd2, 0, 1, -1, 1'b1, 1'b0, 8, 16, 1'b0, 1'b0};
`endif
      vecs[6] = '{1'b0, 32'hFFFF_FFF8, 32'h0000_8000, 16'd3, 0, 0, -1, 1'b0, 1'b0, 12, 24, 1'b0, 1'b0};

      repeat (3) tick();
      chk("rst_req", 32'(req_s.req), 32'h0);
      chk("rst_we", 32'(req_s.a.we), 32'h0);
      chk("rst_addr", req_s.a.addr, 32'h0);
      chk("rst_wdata", req_s.a.wdata, 32'h0);
      chk("rst_be", 32'(req_s.a.be), 32'h0000_000F);
      chk("rst_aid", 32'(req_s.a.aid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_aborted", 32'(aborted), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      rst_n = 1'b1;
      tick();

      // Start while disabled is ignored.
      addr_a = 32'h0000_0100;
      addr_b = 32'h0000_0200;
      num = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("gated_req", 32'(req_s.req), 32'h0);
         chk("gated_busy", 32'(busy), 32'h0);
      end
      en = 1'b1;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i]);
         if (vecs[i].preset == 1 && vecs[i].exp_txns == 8) begin
            chk("plan_a0", mem_rd(vecs[i].a), 32'hAAAA_AAAA);
            chk("plan_a1", mem_rd(vecs[i].a + 32'd4), 32'hBBBB_BBBB);
            chk("plan_b0", mem_rd(vecs[i].b), 32'h1111_1111);
            chk("plan_b1", mem_rd(vecs[i].b + 32'd4), 32'h2222_2222);
         end else if (vecs[i].preset == 2) begin
            for (int k = 0; k < 3; k++) begin
               chk("plan_load_a", mem_rd(vecs[i].a + 32'(k) * 32'd4), 32'(k + 1));
               chk("plan_load_b", mem_rd(vecs[i].b + 32'(k) * 32'd4), 32'(k + 1));
            end
         end
      end

      // Reset in the middle of an operation.
      rv = '{1'b0, 32'h0000_9000, 32'h0000_A000, 16'd2, 0, 0, -1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
      build_model(rv);
      addr_a = rv.a;
      addr_b = rv.b;
      num = rv.n;
      load = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_req", 32'(req_s.req), 32'h0);
      chk("midrst_done", 32'(done), 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      tick();
      chk("postrst_req", 32'(req_s.req), 32'h0);
      chk("postrst_busy", 32'(busy), 32'h0);
      run_op(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
